uart_tx_arbiter: RTL and testbench

//   Packet-level round-robin arbiter sharing the single UART TX FIFO push port

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-level round-robin arbiter sharing one UART TX FIFO push
//               port between NUM_REQ byte-stream requesters, with a stall
//               watchdog that releases an owner idling mid-packet.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_push_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_evt
);

    localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(TIMEOUT - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_RST  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  c_ONE      = NUM_REQ'(1);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_PTR_W-1:0]  r_last_ptr;
    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_timeout_evt;

    logic [DATA_W-1:0]   w_data [NUM_REQ];
    logic                w_locked;
    logic                w_own_valid;
    logic                w_push;
    logic                w_pick_found;
    logic [c_PTR_W-1:0]  w_pick_idx;
    int                  w_cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_locked    = (r_state == c_ST_LOCKED);
    assign w_own_valid = w_locked & req_valid[r_owner];
    assign w_push      = w_own_valid & ~fifo_full;

    assign req_ready      = (w_locked && !fifo_full) ? r_grant : '0;
    assign fifo_push      = w_push;
    assign fifo_push_data = w_push ? w_data[r_owner] : '0;
    assign grant          = r_grant;
    assign busy           = w_locked;
    assign timeout_evt    = r_timeout_evt;

    // Scan from the furthest candidate back to the nearest so the nearest valid
    // requester after r_last_ptr is the one left in w_pick_idx.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_cand       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = int'(r_last_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (req_valid[c_PTR_W'(w_cand)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = c_PTR_W'(w_cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= '0;
            r_owner       <= '0;
            r_last_ptr    <= c_PTR_RST;
            r_wdog        <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_timeout_evt <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pick_found) begin
                        r_grant <= c_ONE << w_pick_idx;
                        r_owner <= w_pick_idx;
                        r_wdog  <= '0;
                        r_state <= c_ST_LOCKED;
                    end
                end
                c_ST_LOCKED: begin
                    if (w_push) begin
                        r_wdog <= '0;
                        if (req_last[r_owner]) begin
                            r_last_ptr <= r_owner;
                            r_grant    <= '0;
                            r_state    <= c_ST_IDLE;
                        end
                    end else if (!w_own_valid) begin
                        // Only a silent owner ages the watchdog; FIFO backpressure holds it.
                        if (r_wdog == c_WDOG_MAX) begin
                            r_timeout_evt <= 1'b1;
                            r_last_ptr    <= r_owner;
                            r_grant       <= '0;
                            r_state       <= c_ST_IDLE;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed and randomized bench for uart_tx_arbiter against a
//               packet-level reference model of the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_push;
    logic [DW-1:0]     fifo_push_data;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              timeout_evt;

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .grant          (grant),
        .busy           (busy),
        .timeout_evt    (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int tick_no  = 0;
    int tevt_cnt = 0;
    logic last_tevt;

    // Each source holds {last, data} bytes; hold forces its valid low.
    logic [8:0]    src_q [NR][$];
    logic [NR-1:0] hold;

    logic [7:0]    log_data [$];
    logic [NR-1:0] log_gnt  [$];
    int            log_tick [$];

    // Reference model: who owns the port, who finished last, how long stalled.
    int m_owner;
    int m_last;
    int m_stall;
    logic m_tevt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_stall = 0;
        m_tevt  = 1'b0;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_gnt.delete();
        log_tick.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_q[i][0][7:0];
                req_last[i]           = src_q[i][0][8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = 8'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
    endtask

    task automatic model_check();
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rdy;
        logic          e_push;
        logic [7:0]    e_data;
        e_gnt  = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
        e_rdy  = fifo_full ? '0 : e_gnt;
        e_push = (m_owner >= 0) ? (req_valid[m_owner] && !fifo_full) : 1'b0;
        e_data = e_push ? req_data[m_owner*DW +: DW] : 8'h00;
        check("grant",       32'(grant),          32'(e_gnt));
        check("busy",        32'(busy),           32'(m_owner >= 0));
        check("req_ready",   32'(req_ready),      32'(e_rdy));
        check("fifo_push",   32'(fifo_push),      32'(e_push));
        check("push_data",   32'(fifo_push_data), 32'(e_data));
        check("timeout_evt", 32'(timeout_evt),    32'(m_tevt));
    endtask

    task automatic model_step();
        int pick;
        if (rst) begin
            model_reset();
            return;
        end
        m_tevt = 1'b0;
        if (m_owner < 0) begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                if (pick < 0 && req_valid[(m_last + k) % NR]) pick = (m_last + k) % NR;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_stall = 0;
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_stall = 0;
            if (req_last[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (!req_valid[m_owner]) begin
            m_stall++;
            if (m_stall == TO) begin
                m_tevt  = 1'b1;
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        tick_no++;
        model_check();
        last_tevt = timeout_evt;
        if (timeout_evt) tevt_cnt++;
        if (fifo_push) begin
            log_data.push_back(fifo_push_data);
            log_gnt.push_back(grant);
            log_tick.push_back(tick_no);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input int idx, input logic [7:0] exp_d,
                             input logic [NR-1:0] exp_g);
        logic [7:0]    od;
        logic [NR-1:0] og;
        od = (idx < log_data.size()) ? log_data[idx] : 8'hxx;
        og = (idx < log_gnt.size())  ? log_gnt[idx]  : 'x;
        check({tag, "_data"},  32'(od), 32'(exp_d));
        check({tag, "_grant"}, 32'(og), 32'(exp_g));
    endtask

    task automatic random_step();
        int r;
        int len;
        if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 4);
            if (src_q[r].size() < 8) begin
                for (int j = 0; j < len; j++) src_q[r].push_back({(j == len - 1), 8'($urandom)});
            end
        end
        fifo_full = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 99) < 3) hold[i] = ~hold[i];
        end
        tick();
    endtask

    initial begin
        int seen;
        int tevt_base;
        rst       = 1'b1;
        fifo_full = 1'b0;
        hold      = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        model_reset();
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Simultaneous requests are served 0, 1, 2 in turn.
        clear_logs();
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[1].push_back({1'b1, 8'hA1});
        src_q[2].push_back({1'b1, 8'hA2});
        repeat (6) tick();
        check("t1_count", 32'(log_data.size()), 32'd3);
        check_log("t1_p0", 0, 8'hA0, 3'b001);
        check_log("t1_p1", 1, 8'hA1, 3'b010);
        check_log("t1_p2", 2, 8'hA2, 3'b100);

        // A packet is never interleaved with a late requester.
        clear_logs();
        src_q[1].push_back({1'b0, 8'h41});
        src_q[1].push_back({1'b0, 8'h42});
        src_q[1].push_back({1'b1, 8'h43});
        tick();
        src_q[0].push_back({1'b1, 8'h30});
        repeat (5) tick();
        check("t2_count", 32'(log_data.size()), 32'd4);
        check_log("t2_p0", 0, 8'h41, 3'b010);
        check_log("t2_p1", 1, 8'h42, 3'b010);
        check_log("t2_p2", 2, 8'h43, 3'b010);
        check_log("t2_p3", 3, 8'h30, 3'b001);

        // FIFO backpressure stalls the owner without aging the watchdog.
        clear_logs();
        for (int j = 0; j < 6; j++) src_q[2].push_back({(j == 5), 8'(8'h10 + j)});
        tick();
        tick();
        fifo_full = 1'b1;
        tevt_base = tevt_cnt;
        repeat (20) tick();
        check("t3_no_push_while_full", 32'(log_data.size()), 32'd1);
        check("t3_no_timeout", 32'(tevt_cnt - tevt_base), 32'd0);
        fifo_full = 1'b0;
        repeat (8) tick();
        check("t3_count", 32'(log_data.size()), 32'd6);
        for (int j = 0; j < 6; j++) check_log("t3_byte", j, 8'(8'h10 + j), 3'b100);

        // Owner goes silent after one byte; watchdog hands the port on.
        clear_logs();
        src_q[1].push_back({1'b0, 8'hB1});
        src_q[1].push_back({1'b0, 8'hB2});
        src_q[1].push_back({1'b1, 8'hB3});
        tick();
        tick();
        hold[1] = 1'b1;
        src_q[2].push_back({1'b1, 8'hC1});
        seen = 0;
        for (int t = 1; t <= 40 && seen == 0; t++) begin
            tick();
            if (last_tevt) seen = t;
        end
        check("t4_timeout_window", 32'(seen >= TO && seen <= TO + 1), 32'd1);
        src_q[1].delete();
        hold[1] = 1'b0;
        repeat (4) tick();
        check("t4_count", 32'(log_data.size()), 32'd2);
        check_log("t4_p0", 0, 8'hB1, 3'b010);
        check_log("t4_p1", 1, 8'hC1, 3'b100);

        // Asynchronous reset mid-packet drops it immediately.
        clear_logs();
        for (int j = 0; j < 4; j++) src_q[0].push_back({(j == 3), 8'(8'hD0 + j)});
        tick();
        tick();
        drive();
        rst = 1'b1;
        #1;
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_push",  32'(fifo_push), 32'd0);
        check("t5_rst_busy",  32'(busy), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        src_q[0].delete();
        clear_logs();
        src_q[1].push_back({1'b1, 8'hE1});
        src_q[0].push_back({1'b1, 8'hE0});
        repeat (5) tick();
        check("t5_count", 32'(log_data.size()), 32'd2);
        check_log("t5_p0", 0, 8'hE0, 3'b001);
        check_log("t5_p1", 1, 8'hE1, 3'b010);

        // Lone requester streaming packets gets one IDLE cycle between them.
        clear_logs();
        src_q[2].push_back({1'b1, 8'h61});
        src_q[2].push_back({1'b1, 8'h62});
        repeat (6) tick();
        check("t6_count", 32'(log_data.size()), 32'd2);
        check_log("t6_p0", 0, 8'h61, 3'b100);
        check_log("t6_p1", 1, 8'h62, 3'b100);
        check("t6_gap", 32'((log_tick.size() > 1) ? (log_tick[1] - log_tick[0]) : -1), 32'd2);

        // Randomized traffic, FIFO backpressure and long stalls.
        repeat (800) random_step();
        hold = '0;
        fifo_full = 1'b0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
